// File: rtl/mem_fill_arbiter_if.sv
// Cache/memory-side bundle for mem_fill_arbiter: miss and store requests in, memory port and
// cache fill strobes out. The arbiter connects through "master", the caches/memory through "slave".
interface mem_fill_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int WORDS  = 8
);
    localparam int WI = $clog2(WORDS);

    // cache-side requests
    logic              icache_miss;
    logic [ADDR_W-1:0] icache_miss_addr;
    logic              dcache_miss;
    logic [ADDR_W-1:0] dcache_miss_addr;
    logic              d_wr_req;
    logic [ADDR_W-1:0] d_wr_addr;
    logic [15:0]       d_wr_data;
    logic              d_wr_ack;

    // memory port
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_rvalid;

    // fill port into the caches
    logic [15:0]       fill_data;
    logic [WI-1:0]     fill_word;
    logic              fill_we_i;
    logic              fill_we_d;
    logic              tag_we_i;
    logic              tag_we_d;
    logic              fill_done_i;
    logic              fill_done_d;
    logic              fsm_busy;

    // FSM state for checkers: 0 IDLE, 1 WRITE, 2 FILL, 3 DONE
    logic [1:0]        dbg_state;

    modport master (
        input  icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
        input  d_wr_req, d_wr_addr, d_wr_data, mem_rdata, mem_rvalid,
        output d_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata,
        output fill_data, fill_word, fill_we_i, fill_we_d, tag_we_i, tag_we_d,
        output fill_done_i, fill_done_d, fsm_busy, dbg_state
    );

    modport slave (
        output icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
        output d_wr_req, d_wr_addr, d_wr_data, mem_rdata, mem_rvalid,
        input  d_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata,
        input  fill_data, fill_word, fill_we_i, fill_we_d, tag_we_i, tag_we_d,
        input  fill_done_i, fill_done_d, fsm_busy, dbg_state
    );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Arbitrates D-cache stores, D misses and I misses onto one pipelined memory port and streams
// each miss back as a whole-block fill into the requesting cache.
module mem_fill_arbiter #(
    parameter int ADDR_W = 16,
    parameter int WORDS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_fill_arbiter_if.master   mif
);
    // Handshake: all requests are level-held by the caches and sampled only in IDLE; a store
    // completes on the one-cycle d_wr_ack pulse, a miss on the one-cycle fill_done pulse.
    localparam int WI    = $clog2(WORDS);
    localparam int OFF_W = WI + 1;
    localparam int HI_W  = ADDR_W - OFF_W;

    localparam logic [WI:0]   WORDS_C = (WI+1)'(WORDS);
    localparam logic [WI-1:0] LAST_C  = WI'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [WI:0]       issue_cnt_q;
    logic [WI-1:0]     recv_cnt_q;
    logic              target_i_q;
    logic [HI_W-1:0]   base_hi_q;

    logic              mem_en_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [15:0]       mem_wdata_q;
    logic              d_wr_ack_q;
    logic              fill_done_i_q;
    logic              fill_done_d_q;
    logic              busy_q;

    logic              rx;
    logic              last_rx;
    logic [HI_W-1:0]   miss_hi;

    always_comb begin
        rx      = (state_q == FILL) && mif.mem_rvalid;
        last_rx = rx && (recv_cnt_q == LAST_C);
        miss_hi = mif.dcache_miss ? mif.dcache_miss_addr[ADDR_W-1:OFF_W]
                                  : mif.icache_miss_addr[ADDR_W-1:OFF_W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            issue_cnt_q   <= '0;
            recv_cnt_q    <= '0;
            target_i_q    <= 1'b0;
            base_hi_q     <= '0;
            mem_en_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            d_wr_ack_q    <= 1'b0;
            fill_done_i_q <= 1'b0;
            fill_done_d_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            d_wr_ack_q    <= 1'b0;
            fill_done_i_q <= 1'b0;
            fill_done_d_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mif.d_wr_req) begin
                        state_q     <= WRITE;
                        busy_q      <= 1'b1;
                        mem_en_q    <= 1'b1;
                        mem_wr_q    <= 1'b1;
                        mem_addr_q  <= mif.d_wr_addr;
                        mem_wdata_q <= mif.d_wr_data;
                        d_wr_ack_q  <= 1'b1;
                    end else if (mif.dcache_miss || mif.icache_miss) begin
                        // Word 0 is launched from the accept edge, so the counter starts at 1.
                        state_q     <= FILL;
                        busy_q      <= 1'b1;
                        target_i_q  <= !mif.dcache_miss;
                        base_hi_q   <= miss_hi;
                        issue_cnt_q <= (WI+1)'(1);
                        recv_cnt_q  <= '0;
                        mem_en_q    <= 1'b1;
                        mem_wr_q    <= 1'b0;
                        mem_addr_q  <= {miss_hi, {OFF_W{1'b0}}};
                    end
                end
                WRITE: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    mem_en_q    <= 1'b0;
                    mem_wr_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                end
                FILL: begin
                    if (last_rx) begin
                        state_q       <= DONE;
                        mem_en_q      <= 1'b0;
                        mem_addr_q    <= '0;
                        fill_done_i_q <= target_i_q;
                        fill_done_d_q <= !target_i_q;
                    end else begin
                        if (rx) begin
                            recv_cnt_q <= recv_cnt_q + WI'(1);
                        end
                        // Concatenated address keeps the burst inside its own block.
                        if (issue_cnt_q < WORDS_C) begin
                            mem_en_q    <= 1'b1;
                            mem_addr_q  <= {base_hi_q, issue_cnt_q[WI-1:0], 1'b0};
                            issue_cnt_q <= issue_cnt_q + (WI+1)'(1);
                        end else begin
                            mem_en_q   <= 1'b0;
                            mem_addr_q <= '0;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Fill strobes follow mem_rvalid in the same cycle; outside FILL they are held at zero.
    assign mif.fill_data   = rx ? mif.mem_rdata : 16'h0000;
    assign mif.fill_word   = rx ? recv_cnt_q : '0;
    assign mif.fill_we_i   = rx && target_i_q;
    assign mif.fill_we_d   = rx && !target_i_q;
    assign mif.tag_we_i    = last_rx && target_i_q;
    assign mif.tag_we_d    = last_rx && !target_i_q;

    assign mif.mem_en      = mem_en_q;
    assign mif.mem_wr      = mem_wr_q;
    assign mif.mem_addr    = mem_addr_q;
    assign mif.mem_wdata   = mem_wdata_q;
    assign mif.d_wr_ack    = d_wr_ack_q;
    assign mif.fill_done_i = fill_done_i_q;
    assign mif.fill_done_d = fill_done_d_q;
    assign mif.fsm_busy    = busy_q;
    assign mif.dbg_state   = state_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{mif.dcache_miss_addr[OFF_W-1:0], mif.icache_miss_addr[OFF_W-1:0]};
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter: a pipelined memory model with mem[a]=a, expected reads,
// fills, done pulses and stores queued by the stimulus and popped by an independent monitor.
module tb_mem_fill_arbiter;
    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    mem_fill_arbiter_if #(.ADDR_W(16), .WORDS(8)) mif ();

    mem_fill_arbiter #(.ADDR_W(16), .WORDS(8)) dut (
        .clk (clk),
        .rst (rst_n),
        .mif (mif)
    );

    // expected response queues
    logic [15:0] exp_rd_q[$];
    logic [21:0] exp_fill_q[$];   // {side_i, tag_we_i, tag_we_d, word, data}
    logic [1:0]  exp_done_q[$];   // {fill_done_i, fill_done_d}
    logic [32:0] exp_wr_q[$];     // {addr, data, ack}

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm, input logic [63:0] got);
        checks++;
        errors++;
        $display("FAIL %s: got %h with nothing expected (t=%0t)", nm, got, $time);
    endtask

    // memory model: a read issued in cycle c returns in cycle c+3
    logic        cap_v;
    logic [15:0] cap_a;
    logic        pv[3];
    logic [15:0] pd[3];

    initial begin
        cap_v = 1'b0;
        cap_a = '0;
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            pv[2] = pv[1];  pd[2] = pd[1];
            pv[1] = pv[0];  pd[1] = pd[0];
            pv[0] = cap_v;  pd[0] = cap_a;
            mif.mem_rvalid = pv[2];
            mif.mem_rdata  = pv[2] ? pd[2] : 16'h0000;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cap_v = mif.mem_en && !mif.mem_wr;
            cap_a = mif.mem_addr;
        end
    end

    // monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (mif.mem_en && !mif.mem_wr) begin
                if (exp_rd_q.size() == 0) fail_now("unexpected_read", 64'(mif.mem_addr));
                else chk("read_addr", 64'(mif.mem_addr), 64'(exp_rd_q.pop_front()));
            end
            if (mif.mem_en && mif.mem_wr) begin
                if (exp_wr_q.size() == 0) fail_now("unexpected_write", 64'({mif.mem_addr, mif.mem_wdata}));
                else chk("write", 64'({mif.mem_addr, mif.mem_wdata, mif.d_wr_ack}), 64'(exp_wr_q.pop_front()));
            end
            if (mif.d_wr_ack && !(mif.mem_en && mif.mem_wr))
                fail_now("ack_without_write", 64'(mif.dbg_state));
            if (mif.fill_we_i && mif.fill_we_d)
                fail_now("both_fill_we", 64'(mif.fill_word));
            if (mif.fill_we_i || mif.fill_we_d) begin
                if (exp_fill_q.size() == 0)
                    fail_now("unexpected_fill", 64'({mif.fill_we_i, mif.fill_word, mif.fill_data}));
                else
                    chk("fill", 64'({mif.fill_we_i, mif.tag_we_i, mif.tag_we_d, mif.fill_word, mif.fill_data}),
                        64'(exp_fill_q.pop_front()));
            end else if (mif.tag_we_i || mif.tag_we_d) begin
                fail_now("tag_we_without_fill", 64'({mif.tag_we_i, mif.tag_we_d}));
            end
            if (mif.fill_done_i || mif.fill_done_d) begin
                if (exp_done_q.size() == 0) fail_now("unexpected_done", 64'({mif.fill_done_i, mif.fill_done_d}));
                else chk("fill_done", 64'({mif.fill_done_i, mif.fill_done_d}), 64'(exp_done_q.pop_front()));
            end
        end
    end

    // driver helpers
    task automatic push_block(input logic side_i, input logic [15:0] addr);
        logic [15:0] base;
        logic [15:0] a;
        logic [2:0]  w;
        base = addr & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            w = 3'(k);
            a = base + {12'd0, w, 1'b0};
            exp_rd_q.push_back(a);
            exp_fill_q.push_back({side_i, side_i && (k == 7), !side_i && (k == 7), w, a});
        end
        exp_done_q.push_back(side_i ? 2'b10 : 2'b01);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // sel: 0 fill_done_d, 1 fill_done_i, 2 mem_en, 3 d_wr_ack, 4 fill_we_d at word w
    task automatic wait_neg(input int sel, input int w, input int max, output int n);
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < max) begin
            @(negedge clk);
            n++;
            case (sel)
                0: hit = mif.fill_done_d;
                1: hit = mif.fill_done_i;
                2: hit = mif.mem_en;
                3: hit = mif.d_wr_ack;
                default: hit = mif.fill_we_d && (int'(mif.fill_word) == w);
            endcase
        end
        if (!hit) fail_now("timeout_wait", 64'(sel));
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({mif.mem_en, mif.mem_wr, mif.mem_addr, mif.mem_wdata, mif.d_wr_ack,
                    mif.fill_data, mif.fill_word, mif.fill_we_i, mif.fill_we_d,
                    mif.tag_we_i, mif.tag_we_d, mif.fill_done_i, mif.fill_done_d,
                    mif.fsm_busy, mif.dbg_state});
    endfunction

    // stimulus
    initial begin
        int n;
        int busy_n;
        int acks;
        rst_n                = 1'b0;
        mif.icache_miss      = 1'b0;
        mif.icache_miss_addr = '0;
        mif.dcache_miss      = 1'b0;
        mif.dcache_miss_addr = '0;
        mif.d_wr_req         = 1'b0;
        mif.d_wr_addr        = '0;
        mif.d_wr_data        = '0;
        #2;
        chk("reset_outputs", all_outputs(), 64'd0);
        #20;
        rst_n = 1'b1;
        step();
        chk("idle_after_reset", all_outputs(), 64'd0);

        // 1: D miss at 0x1236, count busy cycles
        push_block(1'b0, 16'h1236);
        mif.dcache_miss      = 1'b1;
        mif.dcache_miss_addr = 16'h1236;
        busy_n = 0;
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (mif.fsm_busy) busy_n++;
            if (mif.fill_done_d) break;
        end
        chk("t1_done_seen", 64'(mif.fill_done_d), 64'd1);
        chk("t1_busy_cycles", 64'(busy_n), 64'd12);
        mif.dcache_miss = 1'b0;
        repeat (3) step();
        chk("t1_idle", 64'({mif.fsm_busy, mif.dbg_state}), 64'd0);

        // 2: simultaneous I and D miss, D first, I read 2 cycles after fill_done_d
        push_block(1'b0, 16'h2000);
        push_block(1'b1, 16'h0040);
        mif.dcache_miss      = 1'b1;
        mif.dcache_miss_addr = 16'h2000;
        mif.icache_miss      = 1'b1;
        mif.icache_miss_addr = 16'h0040;
        wait_neg(0, 0, 60, n);
        mif.dcache_miss = 1'b0;
        wait_neg(2, 0, 10, n);
        chk("t2_i_issue_gap", 64'(n), 64'd2);
        chk("t2_i_first_addr", 64'(mif.mem_addr), 64'h0040);
        wait_neg(1, 0, 60, n);
        mif.icache_miss = 1'b0;
        repeat (3) step();

        // 3: store raised during word 3 of a fill waits for IDLE
        push_block(1'b0, 16'h7000);
        mif.dcache_miss      = 1'b1;
        mif.dcache_miss_addr = 16'h7000;
        wait_neg(4, 3, 60, n);
        mif.d_wr_req  = 1'b1;
        mif.d_wr_addr = 16'h3000;
        mif.d_wr_data = 16'hBEEF;
        exp_wr_q.push_back({16'h3000, 16'hBEEF, 1'b1});
        acks = 0;
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (mif.d_wr_ack) acks++;
            if (mif.fill_done_d) break;
        end
        chk("t3_no_ack_during_fill", 64'(acks), 64'd0);
        mif.dcache_miss = 1'b0;
        wait_neg(3, 0, 10, n);
        chk("t3_ack_delay", 64'(n), 64'd2);
        mif.d_wr_req = 1'b0;
        repeat (3) step();

        // 4: I miss at the top block stays inside 0xFFF0..0xFFFE
        push_block(1'b1, 16'hFFFA);
        mif.icache_miss      = 1'b1;
        mif.icache_miss_addr = 16'hFFFA;
        wait_neg(1, 0, 60, n);
        mif.icache_miss = 1'b0;
        repeat (3) step();

        // 5: reset after 3 words: 6 reads issued, 3 fills, then nothing
        for (int k = 0; k < 6; k++) exp_rd_q.push_back(16'h4000 + 16'(2 * k));
        for (int k = 0; k < 3; k++)
            exp_fill_q.push_back({3'b000, 3'(k), 16'h4000 + 16'(2 * k)});
        mif.dcache_miss      = 1'b1;
        mif.dcache_miss_addr = 16'h4000;
        wait_neg(4, 2, 60, n);
        #2;
        rst_n           = 1'b0;
        mif.dcache_miss = 1'b0;
        #1;
        chk("t5_reset_outputs", all_outputs(), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        repeat (8) step();
        chk("t5_idle_after_abort", 64'({mif.fsm_busy, mif.dbg_state}), 64'd0);
        push_block(1'b0, 16'h5008);
        mif.dcache_miss      = 1'b1;
        mif.dcache_miss_addr = 16'h5008;
        wait_neg(0, 0, 60, n);
        mif.dcache_miss = 1'b0;
        repeat (3) step();

        // 6: miss dropped two cycles into FILL still completes
        push_block(1'b0, 16'h6000);
        mif.dcache_miss      = 1'b1;
        mif.dcache_miss_addr = 16'h6000;
        step();
        step();
        step();
        mif.dcache_miss = 1'b0;
        wait_neg(0, 0, 60, n);
        repeat (3) step();

        // 7: plain store from IDLE, acked the following cycle
        exp_wr_q.push_back({16'h1234, 16'h5678, 1'b1});
        mif.d_wr_req  = 1'b1;
        mif.d_wr_addr = 16'h1234;
        mif.d_wr_data = 16'h5678;
        wait_neg(3, 0, 10, n);
        chk("t7_ack_delay", 64'(n), 64'd2);
        mif.d_wr_req = 1'b0;
        repeat (10) step();

        chk("rd_queue_empty", 64'(exp_rd_q.size()), 64'd0);
        chk("fill_queue_empty", 64'(exp_fill_q.size()), 64'd0);
        chk("done_queue_empty", 64'(exp_done_q.size()), 64'd0);
        chk("wr_queue_empty", 64'(exp_wr_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
